mem_wif_sram_resp: RTL and testbench

- Responder (memory-side) end of the mem_wif_t bus; serves the fxcpu16 initiator's request/grant/strobe/busy handshake.
- Contains a 16-bit-word SRAM with a configurable wait-state count.
- Sits behind the interface as the CPU's program/data memory model and synthesizable on-chip RAM.
- Port names keep the interface field names; directions are from the responder's side.

---
 rtl/mem_wif_sram_resp.sv | 115 +++++++++++
 tb/tb_mem_wif_sram_resp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wif_sram_resp.sv
// mem_wif_sram_resp: responder-side 16-bit SRAM for the mem_wif_t request/grant/strobe/busy bus
// Ports: clk_i clock, rst_ni async active-low reset; sel_i request (low), stb_i strobe,
// we_i write enable (low=write), addr_i byte address, dat_o write data from initiator;
// dat_i read data, ack_o grant, stb_o accept pulse, cyc_o busy, err_o sticky out-of-range.
// Optional MEM_RESP_PARITY_EN: per-word even parity, par_inj_i corrupts it, par_err_o sticky.
module mem_wif_sram_resp #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 32,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sel_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] dat_o,
  output logic [DW-1:0] dat_i,
  output logic          ack_o,
  output logic          stb_o,
  output logic          cyc_o,
  output logic          err_o
`ifdef MEM_RESP_PARITY_EN
  ,
  input  logic          par_inj_i,
  output logic          par_err_o
`endif
);
  localparam int IW = $clog2(DEPTH);
`ifdef MEM_RESP_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS} st_t;
  st_t           st_q;
  logic          ack_q, stb_q, cyc_q, err_q, we_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wd_q, rd_q;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rw, ww;
  logic          commit, oor;
  always_comb begin
    commit = st_q == ACCESS && cnt_q == 4'd0;
    oor    = addr_q >= AW'(2 * DEPTH);
    rw     = mem[addr_q[IW:1]];
`ifdef MEM_RESP_PARITY_EN
    ww     = {^wd_q ^ par_inj_i, wd_q};
`else
    ww     = wd_q;
`endif
  end
  // SRAM array is never reset; a reset before commit leaves st_q out of ACCESS, dropping the write
  always_ff @(posedge clk_i)
    if (commit && !we_q && !oor) mem[addr_q[IW:1]] <= ww;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      st_q   <= IDLE;
      ack_q  <= 1'b0;
      stb_q  <= 1'b0;
      cyc_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= 4'd0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
    end else begin
      case (st_q)
        IDLE: if (!sel_i) begin
          ack_q <= 1'b1;
          st_q  <= GRANT;
        end
        // sel_i must be released before a strobe counts, so a stale stb_i is never accepted
        GRANT: if (sel_i && stb_i) begin
          addr_q <= addr_i;
          we_q   <= we_i;
          wd_q   <= dat_o;
          ack_q  <= 1'b0;
          stb_q  <= 1'b1;
          cyc_q  <= 1'b1;
          cnt_q  <= 4'(WAIT_CYCLES);
          st_q   <= ACCESS;
        end else if (sel_i) begin
          ack_q <= 1'b0;
          st_q  <= IDLE;
        end
        ACCESS: begin
          stb_q <= 1'b0;
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else begin
            cyc_q <= 1'b0;
            st_q  <= IDLE;
            if (oor) err_q <= 1'b1;
            if (we_q) rd_q <= oor ? '0 : rw[DW-1:0];
          end
        end
        default: st_q <= IDLE;
      endcase
    end
`ifdef MEM_RESP_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) par_err_q <= 1'b0;
    else if (commit && we_q && !oor && ^rw) par_err_q <= 1'b1;
  assign par_err_o = par_err_q;
`endif
  assign dat_i = rd_q;
  assign ack_o = ack_q;
  assign stb_o = stb_q;
  assign cyc_o = cyc_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_mem_wif_sram_resp.sv
// tb_mem_wif_sram_resp: scoreboard bench for mem_wif_sram_resp (WAIT_CYCLES 1 and 4 instances)
module tb_mem_wif_sram_resp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel [2];
  logic        stb [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [15:0] wd [2];
  logic [15:0] rd [2];
  logic        ack [2];
  logic        stbo [2];
  logic        cyc [2];
  logic        err [2];
`ifdef MEM_RESP_PARITY_EN
  logic        inj [2];
  logic        perr [2];
`endif
  int          errors = 0;
  int          checks = 0;
  logic [15:0] model [int];
  logic [15:0] exp_q [$];
  always #5 clk = ~clk;
  mem_wif_sram_resp #(.WAIT_CYCLES(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel[0]), .stb_i(stb[0]), .we_i(we[0]),
    .addr_i(addr[0]), .dat_o(wd[0]), .dat_i(rd[0]), .ack_o(ack[0]), .stb_o(stbo[0]),
    .cyc_o(cyc[0]), .err_o(err[0])
`ifdef MEM_RESP_PARITY_EN
    , .par_inj_i(inj[0]), .par_err_o(perr[0])
`endif
  );
  mem_wif_sram_resp #(.WAIT_CYCLES(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel[1]), .stb_i(stb[1]), .we_i(we[1]),
    .addr_i(addr[1]), .dat_o(wd[1]), .dat_i(rd[1]), .ack_o(ack[1]), .stb_o(stbo[1]),
    .cyc_o(cyc[1]), .err_o(err[1])
`ifdef MEM_RESP_PARITY_EN
    , .par_inj_i(inj[1]), .par_err_o(perr[1])
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] exp_rd(input int u, input logic [31:0] a);
    if (a >= 32'd2048) return 16'h0000;
    return model[u * 4096 + int'(a[10:1])];
  endfunction
  task automatic xfer(input int u, input logic wr, input logic [31:0] a, input logic [15:0] d,
                      input logic keep_stb);
    int n;
    logic [15:0] rd_before;
    rd_before = rd[u];
    @(negedge clk);
    sel[u] = 1'b0;
    @(negedge clk);
    chk("grant", ack[u], 1);
    sel[u]  = 1'b1;
    stb[u]  = 1'b1;
    we[u]   = ~wr;
    addr[u] = a;
    wd[u]   = d;
    if (!wr) exp_q.push_back(exp_rd(u, a));
    @(negedge clk);
    chk("accept_stb", stbo[u], 1);
    chk("accept_cyc", cyc[u], 1);
    chk("accept_ack", ack[u], 0);
    stb[u] = keep_stb;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) chk("stb_pulse", stbo[u], 0);
      if (!cyc[u]) break;
      n++;
    end
    chk("cyc_len", n, u == 1 ? 5 : 2);
    if (wr) begin
      chk("rd_hold", rd[u], rd_before);
      if (a < 32'd2048) model[u * 4096 + int'(a[10:1])] = d;
    end else if (exp_q.size() != 0) chk("rdata", rd[u], exp_q.pop_front());
  endtask
  initial begin
    for (int u = 0; u < 2; u++) begin
      sel[u] = 1'b1; stb[u] = 1'b0; we[u] = 1'b1; addr[u] = '0; wd[u] = '0;
`ifdef MEM_RESP_PARITY_EN
      inj[u] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    chk("rst_ack", ack[0], 0);
    chk("rst_stb", stbo[0], 0);
    chk("rst_cyc", cyc[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_rd", rd[0], 0);
    rst_n = 1'b1;
    xfer(0, 1, 32'h20, 16'hA55A, 0);
    xfer(0, 0, 32'h20, 16'h0000, 0);
    xfer(0, 1, 32'h2, 16'h1234, 1);
    repeat (3) begin
      @(negedge clk);
      chk("no_reaccept_stb", stbo[0], 0);
      chk("no_reaccept_cyc", cyc[0], 0);
    end
    xfer(0, 0, 32'h2, 16'h0000, 0);
    @(negedge clk);
    sel[0] = 1'b0;
    stb[0] = 1'b1;
    @(negedge clk);
    chk("abandon_grant", ack[0], 1);
    @(negedge clk);
    chk("stale_stb_ack", ack[0], 1);
    chk("stale_stb_acc", stbo[0], 0);
    sel[0] = 1'b1;
    stb[0] = 1'b0;
    @(negedge clk);
    chk("abandon_ack", ack[0], 0);
    chk("abandon_stb", stbo[0], 0);
    chk("abandon_cyc", cyc[0], 0);
    @(negedge clk);
    chk("abandon_idle", ack[0], 0);
    xfer(0, 1, 32'h0, 16'h0BAD, 0);
    chk("err_before_oor", err[0], 0);
    xfer(0, 1, 32'h800, 16'hFFFF, 0);
    chk("oor_err_w", err[0], 1);
    xfer(0, 0, 32'h800, 16'h0000, 0);
    xfer(0, 0, 32'h0, 16'h0000, 0);
    chk("oor_err_sticky", err[0], 1);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(64, 1000)) * 2 + 32'($urandom_range(0, 1));
      xfer(0, 1, a, 16'($urandom), 0);
      xfer(0, 0, a, 16'h0000, 0);
    end
`ifdef MEM_RESP_PARITY_EN
    inj[0] = 1'b1;
    xfer(0, 1, 32'h40, 16'h0003, 0);
    inj[0] = 1'b0;
    xfer(0, 0, 32'h40, 16'h0000, 0);
    chk("par_err_inj", perr[0], 1);
`endif
    xfer(1, 1, 32'h4, 16'h0001, 0);
    @(negedge clk);
    sel[1] = 1'b0;
    @(negedge clk);
    chk("u1_grant", ack[1], 1);
    sel[1]  = 1'b1;
    stb[1]  = 1'b1;
    we[1]   = 1'b0;
    addr[1] = 32'h4;
    wd[1]   = 16'hBEEF;
    @(negedge clk);
    chk("u1_accept", stbo[1], 1);
    stb[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("u1_busy", cyc[1], 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", cyc[1], 0);
    chk("midrst_ack", ack[1], 0);
    chk("midrst_stb", stbo[1], 0);
    chk("midrst_rd", rd[1], 0);
    chk("midrst_err0", err[0], 0);
`ifdef MEM_RESP_PARITY_EN
    chk("midrst_perr", perr[0], 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 0, 32'h4, 16'h0000, 0);
    xfer(0, 0, 32'h2, 16'h0000, 0);
`ifdef MEM_RESP_PARITY_EN
    xfer(0, 1, 32'h42, 16'h0007, 0);
    xfer(0, 0, 32'h42, 16'h0000, 0);
    chk("par_err_clean", perr[0], 0);
`endif
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
